// File: rtl/cpu_pkg.sv
// Shared CPU types and widths for the register-file writeback path.
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 2;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; request/grant bit 0 is SRC_ALU, bit 1 is SRC_MEM.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output wb_src_t    o_last
);

  wb_src_t r_last;

  // Starting from MEM makes the first contested grant go to ALU.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= SRC_MEM;
    end else if (o_gnt[0]) begin
      r_last <= SRC_ALU;
    end else if (o_gnt[1]) begin
      r_last <= SRC_MEM;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == SRC_MEM) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  assign o_last = r_last;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write scheduler: busy scoreboard for decode stalls, ALU/MEM
// writeback arbitration and a registered write-port stage.
module regfile_wb_scheduler
  import cpu_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_flush,
  input  logic                i_issue_valid,
  input  logic [REG_AW-1:0]   i_issue_dest,
  output logic                o_issue_ready,
  input  logic                i_alu_wb_valid,
  input  logic [REG_AW-1:0]   i_alu_wb_reg,
  input  logic [DATA_W-1:0]   i_alu_wb_data,
  output logic                o_alu_wb_ready,
  input  logic                i_mem_wb_valid,
  input  logic [REG_AW-1:0]   i_mem_wb_reg,
  input  logic [DATA_W-1:0]   i_mem_wb_data,
  output logic                o_mem_wb_ready,
  output logic                o_rf_we,
  output logic [REG_AW-1:0]   o_rf_waddr,
  output logic [DATA_W-1:0]   o_rf_wdata,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_stray_wb
);

  logic [1:0]          w_gnt;
  wb_src_t             w_last;
  logic                w_any_gnt;
  reg_idx_t            w_gnt_reg;
  logic [DATA_W-1:0]   w_gnt_data;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_rf_we;
  reg_idx_t            r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_stray;

  rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   ({i_mem_wb_valid, i_alu_wb_valid}),
    .o_gnt   (w_gnt),
    .o_last  (w_last)
  );

  assign w_any_gnt  = |w_gnt;
  assign w_gnt_reg  = w_gnt[1] ? i_mem_wb_reg  : i_alu_wb_reg;
  assign w_gnt_data = w_gnt[1] ? i_mem_wb_data : i_alu_wb_data;

  // A busy bit that is clearing this cycle still stalls: one bubble by design.
  assign o_issue_ready = i_issue_valid & ~r_busy[i_issue_dest] & ~i_flush;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (r_rf_we)       w_busy_nxt[r_rf_waddr]   = 1'b0;
      if (o_issue_ready) w_busy_nxt[i_issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_busy     <= '0;
      r_stray    <= 1'b0;
    end else begin
      r_rf_we <= w_any_gnt;
      if (w_any_gnt) begin
        r_rf_waddr <= w_gnt_reg;
        r_rf_wdata <= w_gnt_data;
      end
      r_busy <= w_busy_nxt;
      if (w_any_gnt && !r_busy[w_gnt_reg]) r_stray <= 1'b1;
    end
  end

  assign o_alu_wb_ready = w_gnt[0];
  assign o_mem_wb_ready = w_gnt[1];
  assign o_rf_we        = r_rf_we;
  assign o_rf_waddr     = r_rf_waddr;
  assign o_rf_wdata     = r_rf_wdata;
  assign o_busy         = r_busy;
  assign o_stray_wb     = r_stray;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: hand-computed expectations per cycle.
module tb_regfile_wb_scheduler;
  import cpu_pkg::*;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic                i_flush;
  logic                i_issue_valid;
  logic [REG_AW-1:0]   i_issue_dest;
  logic                o_issue_ready;
  logic                i_alu_wb_valid;
  logic [REG_AW-1:0]   i_alu_wb_reg;
  logic [DATA_W-1:0]   i_alu_wb_data;
  logic                o_alu_wb_ready;
  logic                i_mem_wb_valid;
  logic [REG_AW-1:0]   i_mem_wb_reg;
  logic [DATA_W-1:0]   i_mem_wb_data;
  logic                o_mem_wb_ready;
  logic                o_rf_we;
  logic [REG_AW-1:0]   o_rf_waddr;
  logic [DATA_W-1:0]   o_rf_wdata;
  logic [NUM_REGS-1:0] o_busy;
  logic                o_stray_wb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  regfile_wb_scheduler dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_issue_valid  (i_issue_valid),
    .i_issue_dest   (i_issue_dest),
    .o_issue_ready  (o_issue_ready),
    .i_alu_wb_valid (i_alu_wb_valid),
    .i_alu_wb_reg   (i_alu_wb_reg),
    .i_alu_wb_data  (i_alu_wb_data),
    .o_alu_wb_ready (o_alu_wb_ready),
    .i_mem_wb_valid (i_mem_wb_valid),
    .i_mem_wb_reg   (i_mem_wb_reg),
    .i_mem_wb_data  (i_mem_wb_data),
    .o_mem_wb_ready (o_mem_wb_ready),
    .o_rf_we        (o_rf_we),
    .o_rf_waddr     (o_rf_waddr),
    .o_rf_wdata     (o_rf_wdata),
    .o_busy         (o_busy),
    .o_stray_wb     (o_stray_wb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    i_flush        = 1'b0;
    i_issue_valid  = 1'b0;
    i_issue_dest   = '0;
    i_alu_wb_valid = 1'b0;
    i_alu_wb_reg   = '0;
    i_alu_wb_data  = '0;
    i_mem_wb_valid = 1'b0;
    i_mem_wb_reg   = '0;
    i_mem_wb_data  = '0;
  endtask

  // Advance to just after the next rising edge; inputs are then driven for that cycle.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [REG_AW-1:0] d);
    i_issue_valid = 1'b1;
    i_issue_dest  = d;
  endtask

  task automatic alu(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    i_alu_wb_valid = 1'b1;
    i_alu_wb_reg   = r;
    i_alu_wb_data  = d;
  endtask

  task automatic mem(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    i_mem_wb_valid = 1'b1;
    i_mem_wb_reg   = r;
    i_mem_wb_data  = d;
  endtask

  initial begin
    idle();
    i_reset = 1'b1;
    cyc(); cyc();
    i_reset = 1'b0;
    #2;
    chk("rst_we",    32'(o_rf_we),        0);
    chk("rst_waddr", 32'(o_rf_waddr),     0);
    chk("rst_wdata", 32'(o_rf_wdata),     0);
    chk("rst_busy",  32'(o_busy),         0);
    chk("rst_stray", 32'(o_stray_wb),     0);
    chk("rst_aready",32'(o_alu_wb_ready), 0);

    // Issue R2, then ALU writeback to R2.
    cyc(); issue(2'd2); #2;
    chk("t1_iready", 32'(o_issue_ready), 1);
    cyc(); idle(); alu(2'd2, 8'hA5); #2;
    chk("t1_busy_set", 32'(o_busy), 32'h4);
    chk("t1_aready",   32'(o_alu_wb_ready), 1);
    chk("t1_mready",   32'(o_mem_wb_ready), 0);
    cyc(); idle(); #2;
    chk("t1_we",    32'(o_rf_we),    1);
    chk("t1_waddr", 32'(o_rf_waddr), 2);
    chk("t1_wdata", 32'(o_rf_wdata), 32'hA5);
    chk("t1_busy_hold", 32'(o_busy), 32'h4);
    cyc(); #2;
    chk("t1_we_off",  32'(o_rf_we),    0);
    chk("t1_busy_clr",32'(o_busy),     0);
    chk("t1_waddr_hold", 32'(o_rf_waddr), 2);
    chk("t1_wdata_hold", 32'(o_rf_wdata), 32'hA5);
    chk("t1_stray",   32'(o_stray_wb), 0);

    // Fresh reset so the first contested grant goes to ALU.
    cyc(); i_reset = 1'b1;
    cyc(); i_reset = 1'b0;
    issue(2'd1); #2;
    chk("t2_iready_r1", 32'(o_issue_ready), 1);
    cyc(); issue(2'd3); #2;
    chk("t2_iready_r3", 32'(o_issue_ready), 1);
    cyc(); idle(); alu(2'd1, 8'h11); mem(2'd3, 8'h33); #2;
    chk("t2_busy",   32'(o_busy), 32'hA);
    chk("t2_aready", 32'(o_alu_wb_ready), 1);
    chk("t2_mready0",32'(o_mem_wb_ready), 0);
    cyc(); i_alu_wb_valid = 1'b0; #2;
    chk("t2_mready1",32'(o_mem_wb_ready), 1);
    chk("t2_we1",    32'(o_rf_we),    1);
    chk("t2_waddr1", 32'(o_rf_waddr), 1);
    chk("t2_wdata1", 32'(o_rf_wdata), 32'h11);
    cyc(); idle(); #2;
    chk("t2_we2",    32'(o_rf_we),    1);
    chk("t2_waddr2", 32'(o_rf_waddr), 3);
    chk("t2_wdata2", 32'(o_rf_wdata), 32'h33);
    chk("t2_busy_r1clr", 32'(o_busy), 32'h8);
    cyc(); #2;
    chk("t2_busy_clr", 32'(o_busy),  0);
    chk("t2_we_off",   32'(o_rf_we), 0);

    // Stall on busy R1, one bubble after the write.
    issue(2'd1); #2;
    chk("t3_iready0", 32'(o_issue_ready), 1);
    cyc(); alu(2'd1, 8'h77); #2;
    chk("t3_stall_busy", 32'(o_issue_ready), 0);
    chk("t3_aready",     32'(o_alu_wb_ready), 1);
    cyc(); i_alu_wb_valid = 1'b0; #2;
    chk("t3_we",         32'(o_rf_we),    1);
    chk("t3_waddr",      32'(o_rf_waddr), 1);
    chk("t3_stall_clr",  32'(o_issue_ready), 0);
    cyc(); #2;
    chk("t3_busy0",      32'(o_busy), 0);
    chk("t3_iready1",    32'(o_issue_ready), 1);
    cyc(); idle(); #2;
    chk("t3_busy_reset", 32'(o_busy), 32'h2);

    // Stray writeback to R0 while not busy.
    alu(2'd0, 8'h5A); #2;
    chk("t4_aready", 32'(o_alu_wb_ready), 1);
    chk("t4_stray0", 32'(o_stray_wb), 0);
    cyc(); idle(); #2;
    chk("t4_we",     32'(o_rf_we),    1);
    chk("t4_waddr",  32'(o_rf_waddr), 0);
    chk("t4_wdata",  32'(o_rf_wdata), 32'h5A);
    chk("t4_stray1", 32'(o_stray_wb), 1);
    cyc(); mem(2'd2, 8'h22);
    cyc(); idle();
    cyc(); #2;
    chk("t4_stray_sticky", 32'(o_stray_wb), 1);

    // All busy, then flush concurrent with a MEM grant to R3.
    cyc(); issue(2'd0);
    cyc(); issue(2'd2);
    cyc(); issue(2'd3);
    cyc(); idle(); #2;
    chk("t5_busy_all", 32'(o_busy), 32'hF);
    cyc(); i_flush = 1'b1; issue(2'd1); mem(2'd3, 8'hC3); #2;
    chk("t5_iready_flush", 32'(o_issue_ready), 0);
    chk("t5_mready",       32'(o_mem_wb_ready), 1);
    cyc(); idle(); #2;
    chk("t5_busy_flushed", 32'(o_busy),     0);
    chk("t5_we",           32'(o_rf_we),    1);
    chk("t5_waddr",        32'(o_rf_waddr), 3);
    chk("t5_wdata",        32'(o_rf_wdata), 32'hC3);
    cyc(); i_flush = 1'b1; issue(2'd0); #2;
    chk("t5_flush_blocks", 32'(o_issue_ready), 0);
    cyc(); i_flush = 1'b0; #2;
    chk("t5_iready_after", 32'(o_issue_ready), 1);
    cyc(); idle(); #2;
    chk("t5_busy_r0", 32'(o_busy), 32'h1);

    // Reset right after a grant drops the pending write.
    alu(2'd0, 8'h99); #2;
    chk("t6_aready", 32'(o_alu_wb_ready), 1);
    cyc(); idle(); i_reset = 1'b1; #2;
    chk("t6_we_pending", 32'(o_rf_we), 1);
    cyc(); i_reset = 1'b0; #2;
    chk("t6_we_dropped", 32'(o_rf_we),    0);
    chk("t6_busy",       32'(o_busy),     0);
    chk("t6_stray",      32'(o_stray_wb), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
